sd_wave_writer: RTL and testbench

Fills the oscillator/bytes-screen sample BRAM from the SD card: on a UI update trigger it issues sector reads to the SD controller, packs the incoming byte stream into LINE_WIDTH-bit BRAM lines and writes them through the BRAM write port (port A). It is the write-side counterpart of the line-wide sample reader, which unpacks the same lines by sample index. The SD controller runs on its own 25 MHz clock; this block lives on the system clock.

---
 rtl/sd_wave_writer_pkg.sv | 18 +
 rtl/sd_wave_writer_sync_2ff.sv | 24 ++
 rtl/sd_wave_writer.sv | 165 ++++++++++++++++
 tb/tb_sd_wave_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_wave_writer_pkg.sv
// Shared audio parameters and the writer state encoding for the SD-to-BRAM sample loader.
package sd_wave_writer_pkg;

    localparam int DEF_SAMPLE_WIDTH     = 16;
    localparam int DEF_LINE_WIDTH       = 512;
    localparam int DEF_SECTOR_BYTES     = 512;
    localparam int DEF_SAMPLES_PER_LINE = DEF_LINE_WIDTH / DEF_SAMPLE_WIDTH;
    localparam int DEF_BYTES_PER_LINE   = DEF_LINE_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_ISSUE,
        ST_RECEIVE,
        ST_DONE
    } wr_state_t;

endpackage

// File: rtl/sd_wave_writer_sync_2ff.sv
// Two-flop synchronizer for slow status levels crossing into the system clock.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta;

    // Two register stages; the first may go metastable, the second is used.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            meta  <= '0;
            q_out <= '0;
        end else begin
            meta  <= d_in;
            q_out <= meta;
        end
    end

endmodule

// File: rtl/sd_wave_writer.sv
// Loads wave samples from the SD card into the line-wide sample BRAM:
// issues sector reads, packs bytes big-endian into lines and writes them on port A.
module sd_wave_writer
    import sd_wave_writer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int LINE_WIDTH   = DEF_LINE_WIDTH,
    parameter int BRAM_DEPTH   = 4096,
    parameter int WW_WIDTH     = 18,
    parameter int SECTOR_BYTES = DEF_SECTOR_BYTES
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [WW_WIDTH-1:0]           wave_width_in,
    input  logic [31:0]                   sd_base_addr_in,
    input  logic                          sd_ready_in,
    input  logic                          sd_byte_available_in,
    input  logic [7:0]                    sd_dout_in,
    output logic                          sd_rd_out,
    output logic [31:0]                   sd_addr_out,
    output logic [$clog2(BRAM_DEPTH)-1:0] bram_addr_out,
    output logic [LINE_WIDTH-1:0]         bram_data_out,
    output logic                          bram_we_out,
    output logic                          busy_out,
    output logic                          done_out
);

    localparam int ADDR_W = $clog2(BRAM_DEPTH);
    localparam int BPL    = LINE_WIDTH / 8;
    localparam int LB_W   = $clog2(BPL);
    localparam int SB_W   = $clog2(SECTOR_BYTES);
    localparam logic [31:0] MAX_BYTES = 32'(BRAM_DEPTH * BPL);

    // Useful byte count of a load: whole samples requested, capped at a full BRAM.
    // Tracking bytes (not lines) lets the tail of a partial last line stay zero.
    function automatic logic [31:0] load_bytes(input logic [WW_WIDTH-1:0] ww);
        logic [31:0] b;
        b = 32'(ww) * 32'(SAMPLE_WIDTH / 8);
        return (b > MAX_BYTES) ? MAX_BYTES : b;
    endfunction

    wr_state_t             state, state_nxt;
    logic [1:0]            status_sync;
    logic                  ready_sync, avail_sync, avail_prev;
    logic                  byte_capture, sector_end, line_complete;
    logic                  pending, load_go;
    logic [WW_WIDTH-1:0]   pending_ww;
    logic [31:0]           go_bytes, bytes_left, bytes_left_nxt;
    logic [SB_W-1:0]       sector_byte;
    logic [LB_W-1:0]       line_byte;
    logic [ADDR_W-1:0]     line_idx;
    logic [LINE_WIDTH-1:0] line_reg, line_nxt;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({sd_ready_in, sd_byte_available_in}),
        .q_out  (status_sync)
    );

    assign ready_sync   = status_sync[1];
    assign avail_sync   = status_sync[0];
    assign byte_capture = (state == ST_RECEIVE) && avail_sync && !avail_prev;
    assign sector_end   = byte_capture && (sector_byte == SB_W'(SECTOR_BYTES - 1));
    // A load starts from IDLE on request, or straight out of DONE when one is queued.
    assign load_go      = ((state == ST_IDLE) && start_in) ||
                          ((state == ST_DONE) && (pending || start_in));
    assign go_bytes     = load_bytes(((state == ST_DONE) && pending) ? pending_ww : wave_width_in);
    assign bytes_left_nxt = (byte_capture && (bytes_left != 32'd0)) ? bytes_left - 32'd1 : bytes_left;
    assign line_complete  = byte_capture && (bytes_left != 32'd0) &&
                            ((line_byte == LB_W'(BPL - 1)) || (bytes_left == 32'd1));

    // Drop the incoming byte into its big-endian slot of the line being built.
    always_comb begin
        line_nxt = line_reg;
        line_nxt[LINE_WIDTH - 1 - 8 * int'(line_byte) -: 8] = sd_dout_in;
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a sector is always drained before leaving RECEIVE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (load_go) state_nxt = (go_bytes == 32'd0) ? ST_DONE : ST_WAIT_READY;
            ST_WAIT_READY: if (ready_sync) state_nxt = ST_ISSUE;
            ST_ISSUE:      if (!ready_sync) state_nxt = ST_RECEIVE;
            ST_RECEIVE:    if (sector_end) state_nxt = (bytes_left_nxt != 32'd0) ? ST_WAIT_READY : ST_DONE;
            ST_DONE:       state_nxt = load_go ? ((go_bytes == 32'd0) ? ST_DONE : ST_WAIT_READY) : ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        sd_rd_out = (state == ST_ISSUE);
        busy_out  = (state != ST_IDLE);
        done_out  = (state == ST_DONE);
    end

    // One-deep request queue; the wave width is frozen when the request is queued.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending    <= 1'b0;
            pending_ww <= '0;
        end else if (load_go) begin
            pending <= (state == ST_DONE) && pending && start_in;
            if ((state == ST_DONE) && pending && start_in) pending_ww <= wave_width_in;
        end else if (start_in && (state != ST_IDLE) && !pending) begin
            pending    <= 1'b1;
            pending_ww <= wave_width_in;
        end
    end

    // Byte counting, line packing, BRAM writes and sector address stepping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            avail_prev    <= 1'b0;
            bytes_left    <= '0;
            sector_byte   <= '0;
            line_byte     <= '0;
            line_idx      <= '0;
            line_reg      <= '0;
            sd_addr_out   <= '0;
            bram_we_out   <= 1'b0;
            bram_addr_out <= '0;
            bram_data_out <= '0;
        end else begin
            avail_prev  <= avail_sync;
            bram_we_out <= 1'b0;
            if (load_go) begin
                bytes_left  <= go_bytes;
                sector_byte <= '0;
                line_byte   <= '0;
                line_idx    <= '0;
                line_reg    <= '0;
                sd_addr_out <= sd_base_addr_in;
            end
            if (byte_capture) begin
                bytes_left  <= bytes_left_nxt;
                sector_byte <= sector_end ? '0 : sector_byte + 1'b1;
                if (bytes_left != 32'd0) begin
                    if (line_complete) begin
                        bram_we_out   <= 1'b1;
                        bram_addr_out <= line_idx;
                        bram_data_out <= line_nxt;
                        line_reg      <= '0;
                        line_byte     <= '0;
                        line_idx      <= line_idx + 1'b1;
                    end else begin
                        line_reg  <= line_nxt;
                        line_byte <= line_byte + 1'b1;
                    end
                end
                if (sector_end && (bytes_left_nxt != 32'd0)) sd_addr_out <= sd_addr_out + 32'(SECTOR_BYTES);
            end
        end
    end

endmodule

// File: tb/tb_sd_wave_writer.sv
// Bench for sd_wave_writer: behavioural SD card model, BRAM write recorder and
// expected lines computed directly from card contents and requested sample counts.
module tb_sd_wave_writer;

    localparam int CARD = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [17:0]  ww = '0;
    logic [31:0]  base = '0;
    logic         sd_ready = 1'b1;
    logic         sd_avail = 1'b0;
    logic [7:0]   sd_dout = '0;
    logic         sd_rd;
    logic [31:0]  sd_addr;
    logic [11:0]  bram_addr;
    logic [511:0] bram_data;
    logic         bram_we;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   card [0:CARD-1];
    logic [511:0] mem [int];
    int           wr_count = 0;
    int           max_wr_addr = -1;
    int           rd_count = 0;
    logic         rd_prev = 1'b0;
    logic [31:0]  rd_addrs [$];

    sd_wave_writer dut (
        .clk_in               (clk),
        .rst_in               (rst),
        .start_in             (start),
        .wave_width_in        (ww),
        .sd_base_addr_in      (base),
        .sd_ready_in          (sd_ready),
        .sd_byte_available_in (sd_avail),
        .sd_dout_in           (sd_dout),
        .sd_rd_out            (sd_rd),
        .sd_addr_out          (sd_addr),
        .bram_addr_out        (bram_addr),
        .bram_data_out        (bram_data),
        .bram_we_out          (bram_we),
        .busy_out             (busy),
        .done_out             (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: lines needed for a sample count, capped at BRAM depth.
    function automatic int n_lines(input int w);
        int n;
        n = (w + 31) / 32;
        return (n > 4096) ? 4096 : n;
    endfunction

    // Reference: a line holds bytes L*64.. of the stream, only those within 2*w bytes.
    function automatic logic [511:0] exp_line(input int b, input int w, input int l);
        logic [511:0] v;
        v = '0;
        for (int j = 0; j < 64; j++) begin
            if (l * 64 + j < 2 * w) v[511 - 8 * j -: 8] = card[(b + l * 64 + j) % CARD];
        end
        return v;
    endfunction

    // BRAM write recorder and SD read request counter.
    always @(negedge clk) begin
        if (bram_we) begin
            mem[int'(bram_addr)] = bram_data;
            wr_count++;
            if (int'(bram_addr) > max_wr_addr) max_wr_addr = int'(bram_addr);
        end
        if (sd_rd && !rd_prev) begin
            rd_count++;
            rd_addrs.push_back(sd_addr);
        end
        rd_prev = sd_rd;
    end

    // SD controller model: on a read request, drop ready and stream one sector.
    always begin
        logic [31:0] a;
        @(negedge clk);
        if (sd_rd && sd_ready && !rst) begin
            a = sd_addr;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            sd_ready = 1'b0;
            repeat (4) @(negedge clk);
            for (int i = 0; i < 512; i++) begin
                if (rst) break;
                sd_dout  = card[(a + i) % CARD];
                sd_avail = 1'b1;
                repeat ($urandom_range(3, 4)) @(negedge clk);
                sd_avail = 1'b0;
                repeat (3) @(negedge clk);
            end
            sd_avail = 1'b0;
            sd_ready = 1'b1;
        end
    end

    task automatic clear_model();
        mem.delete();
        wr_count    = 0;
        max_wr_addr = -1;
        rd_count    = 0;
        rd_addrs.delete();
    endtask

    task automatic start_load(input int w, input int b);
        @(negedge clk);
        ww    = 18'(w);
        base  = 32'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 20000; c++) begin
            if (done) break;
            @(negedge clk);
        end
        check_val({tag, "_done"}, done, 1'b1);
    endtask

    task automatic verify(input string tag, input int b, input int w);
        int nl;
        nl = n_lines(w);
        check_val({tag, "_wr_count"}, wr_count, nl);
        check_val({tag, "_rd_count"}, rd_count, (nl * 64 + 511) / 512);
        if (nl > 0) check_val({tag, "_max_addr"}, max_wr_addr, nl - 1);
        if (rd_addrs.size() > 0) check_val({tag, "_rd_addr0"}, rd_addrs[0], b);
        for (int l = 0; l < nl; l++)
            check_val($sformatf("%s_line%0d", tag, l), mem.exists(l) ? mem[l] : {512{1'bx}}, exp_line(b, w, l));
    endtask

    task automatic run_full(input string tag, input int w, input int b);
        clear_model();
        start_load(w, b);
        check_val({tag, "_busy"}, busy, 1'b1);
        wait_done(tag);
        verify(tag, b, w);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 1'b0);
        check_val({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        logic [511:0] line;
        logic         busy_drop;
        int           w, b;

        for (int i = 0; i < CARD; i++) card[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) card[i] = 8'(i);

        repeat (3) @(negedge clk);
        check_val("rst_sd_rd", sd_rd, 1'b0);
        check_val("rst_sd_addr", sd_addr, 32'd0);
        check_val("rst_bram_we", bram_we, 1'b0);
        check_val("rst_bram_addr", bram_addr, 12'd0);
        check_val("rst_bram_data", bram_data, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // One full line, counting bytes.
        run_full("ww32", 32, 0);
        line = mem.exists(0) ? mem[0] : '0;
        check_val("ww32_sample0", line[511:496], 16'h0001);

        // Ten lines across two sectors.
        run_full("ww300", 300, 0);
        if (rd_addrs.size() > 1) check_val("ww300_rd_addr1", rd_addrs[1], 32'd512);
        else check_val("ww300_rd_addr1_missing", rd_addrs.size(), 2);

        // Partial second line.
        run_full("ww40", 40, 1024);
        line = mem.exists(1) ? mem[1] : {512{1'bx}};
        check_val("ww40_tail_zero", line[383:0], '0);

        // Zero samples: immediate done, no SD access.
        clear_model();
        start_load(0, 0);
        check_val("ww0_done", done, 1'b1);
        repeat (5) @(negedge clk);
        check_val("ww0_rd_count", rd_count, 0);
        check_val("ww0_wr_count", wr_count, 0);
        check_val("ww0_idle", busy, 1'b0);

        // Two requests while busy collapse into one load with the first queued width.
        clear_model();
        start_load(32, 0);
        repeat (40) @(negedge clk);
        ww = 18'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        ww = 18'd96; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ww = '0;
        wait_done("pend_first");
        check_val("pend_first_wr", wr_count, 1);
        check_val("pend_first_line", mem.exists(0) ? mem[0] : {512{1'bx}}, exp_line(0, 32, 0));
        clear_model();
        busy_drop = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (!busy) busy_drop = 1'b1;
            if (done) break;
        end
        check_val("pend_second_done", done, 1'b1);
        check_val("pend_busy_held", busy_drop, 1'b0);
        verify("pend_second", 0, 64);
        @(negedge clk);
        check_val("pend_no_third_done", done, 1'b0);
        check_val("pend_no_third_busy", busy, 1'b0);

        // Reset in the middle of receiving.
        clear_model();
        start_load(300, 512);
        for (int c = 0; c < 20000; c++) begin
            if (wr_count >= 2) break;
            @(negedge clk);
        end
        check_val("rstmid_progress", wr_count >= 2, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rstmid_sd_rd", sd_rd, 1'b0);
        check_val("rstmid_sd_addr", sd_addr, 32'd0);
        check_val("rstmid_bram_we", bram_we, 1'b0);
        check_val("rstmid_bram_addr", bram_addr, 12'd0);
        check_val("rstmid_bram_data", bram_data, '0);
        check_val("rstmid_busy", busy, 1'b0);
        check_val("rstmid_done", done, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (sd_ready) break;
            @(negedge clk);
        end
        check_val("rstmid_card_idle", sd_ready, 1'b1);
        repeat (4) @(negedge clk);
        run_full("after_rst", 64, 0);

        // Randomized loads.
        for (int r = 0; r < 2; r++) begin
            w = $urandom_range(1, 400);
            b = 512 * $urandom_range(0, 7);
            run_full($sformatf("rand%0d", r), w, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
